// File: rtl/gray_step_ctrl_pkg.sv
// gray_ctrl_pkg: opcodes, FSM states and Gray helpers shared by the gray_step_ctrl slice
package gray_ctrl_pkg;
  localparam logic [1:0] OP_STEP  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SEEK  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;
  localparam logic [2:0] GRAY_LAST  = 3'b100;
  localparam logic [2:0] GRAY_FIRST = 3'b000;
  typedef enum logic [2:0] {IDLE, STEP, CLEAR, SEEK, DONE} state_t;
  function automatic logic [2:0] gray_next(input logic [2:0] g);
    logic [2:0] b;
    b = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    b = b + 3'd1;
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_step_ctrl_if.sv
// gray_step_ctrl_if: command handshake (CmdValid/CmdReady, CmdOp, CmdArg); master issues, slave accepts
interface gray_step_ctrl_if #(parameter int STEP_W = 8);
  logic              CmdValid;
  logic              CmdReady;
  logic [1:0]        CmdOp;
  logic [STEP_W-1:0] CmdArg;
  modport master(output CmdValid, CmdOp, CmdArg, input CmdReady);
  modport slave(input CmdValid, CmdOp, CmdArg, output CmdReady);
endinterface

// File: rtl/gray_step_ctrl_wrap_cnt.sv
// gray_wrap_cnt: saturating wrap counter; ports Clk, Reset (async), inc, clr (wins over inc), cnt
module gray_wrap_cnt #(parameter int WRAP_W = 8) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              inc,
  input  logic              clr,
  output logic [WRAP_W-1:0] cnt
);
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + WRAP_W'(1);
endmodule

// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: STEP/CLEAR/SEEK sequencer for an external Gray counter; ports Clk, Reset, cmd (slave), GrayIn, OvfIn, CntEn, CntReset, Busy, Done, WrapCnt, OvfSeen
module gray_step_ctrl
  import gray_ctrl_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  gray_step_ctrl_if.slave   cmd,
  input  logic [2:0]        GrayIn,
  input  logic              OvfIn,
  output logic              CntEn,
  output logic              CntReset,
  output logic              Busy,
  output logic              Done,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              OvfSeen
);
  state_t            state, nxt;
  logic [STEP_W-1:0] remain;
  logic [2:0]        target;
  logic              acc;
  assign cmd.CmdReady = state == IDLE && !Reset;
  assign acc          = cmd.CmdValid && cmd.CmdReady;
  assign Done         = state == DONE;
  assign Busy         = state != IDLE;
  assign CntReset     = Reset | (state == CLEAR);
  // SEEK finishes on the edge whose enable lands on the target, so d enables give Done in cycle d+1
  always_comb begin
    nxt   = state;
    CntEn = 1'b0;
    case (state)
      IDLE:
        if (acc)
          nxt = cmd.CmdOp == OP_CLEAR ? CLEAR :
                cmd.CmdOp == OP_SEEK  ? (GrayIn == cmd.CmdArg[2:0] ? DONE : SEEK) :
                cmd.CmdOp == OP_STEP && cmd.CmdArg != '0 ? STEP : DONE;
      STEP: begin
        CntEn = 1'b1;
        if (remain == STEP_W'(1)) nxt = DONE;
      end
      CLEAR: nxt = DONE;
      SEEK: begin
        CntEn = GrayIn != target;
        if (GrayIn == target || gray_next(GrayIn) == target) nxt = DONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state   <= IDLE;
      remain  <= '0;
      target  <= GRAY_FIRST;
      OvfSeen <= 1'b0;
    end else begin
      state   <= nxt;
      OvfSeen <= OvfIn;
      if (acc) begin
        remain <= cmd.CmdArg;
        target <= cmd.CmdArg[2:0];
      end else if (state == STEP) remain <= remain - STEP_W'(1);
    end
  gray_wrap_cnt #(.WRAP_W(WRAP_W)) u_wrap (
    .Clk  (Clk),
    .Reset(Reset),
    .inc  (CntEn && GrayIn == GRAY_LAST),
    .clr  (state == CLEAR),
    .cnt  (WrapCnt)
  );
endmodule

// File: tb/tb_gray_step_ctrl.sv
// tb_gray_step_ctrl: drives gray_step_ctrl with a behavioural Gray counter and checks it against a position/wrap model
module tb_gray_step_ctrl;
  localparam logic [2:0] TAB [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] gray;
  logic       ovf, ovf_d;
  logic       CntEn, CntReset, Busy, Done, OvfSeen;
  logic [7:0] WrapCnt;
  int passed = 0, total = 0;
  int pos = 0, wraps = 0;
  bit ovf_m = 0;
  int m_en, m_rst, m_done, lag_err = 0;
  logic [2:0] gq[$];
  always #5 Clk = ~Clk;
  gray_step_ctrl_if #(.STEP_W(8)) cmd ();
  gray_step_ctrl #(.STEP_W(8), .WRAP_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .cmd(cmd), .GrayIn(gray), .OvfIn(ovf), .CntEn(CntEn),
    .CntReset(CntReset), .Busy(Busy), .Done(Done), .WrapCnt(WrapCnt), .OvfSeen(OvfSeen)
  );
  function automatic int gidx(input logic [2:0] g);
    for (int i = 0; i < 8; i++) if (TAB[i] == g) return i;
    return 0;
  endfunction
  always_ff @(posedge Clk)
    if (CntReset) begin
      gray <= 3'b000;
      ovf  <= 1'b0;
    end else if (CntEn) begin
      gray <= TAB[(gidx(gray) + 1) % 8];
      if (gray == 3'b100) ovf <= 1'b1;
    end
  always_ff @(posedge Clk) ovf_d <= ovf;
  function automatic int sat(input int w);
    return w > 255 ? 255 : w;
  endfunction
  task automatic model_cmd(input logic [1:0] op, input logic [7:0] arg, output int en, output int dc);
    logic [2:0] t;
    t = arg[2:0];
    en = op == 2'b00 ? int'(arg) : op == 2'b10 ? (gidx(t) - pos + 8) % 8 : 0;
    dc = op == 2'b01 ? 2 : en + 1;
    if (op == 2'b01) begin
      pos = 0; wraps = 0; ovf_m = 0;
    end else begin
      wraps += (pos + en) / 8;
      if (pos + en >= 8) ovf_m = 1;
      pos = (pos + en) % 8;
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    @(negedge Clk);
    cmd.CmdValid = 1'b1; cmd.CmdOp = op; cmd.CmdArg = arg;
    @(posedge Clk);
    #1;
    cmd.CmdValid = 1'b0; cmd.CmdOp = 2'($urandom); cmd.CmdArg = 8'($urandom);
  endtask
  task automatic monitor();
    m_en = 0; m_rst = 0; m_done = 0;
    gq.delete();
    for (int k = 1; k <= 600; k++) begin
      @(negedge Clk);
      gq.push_back(gray);
      if (ovf_d !== OvfSeen) lag_err++;
      if (CntEn) m_en++;
      if (CntReset) m_rst++;
      if (Done) begin
        m_done = k;
        break;
      end
    end
  endtask
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, output int e, output int d);
    model_cmd(op, arg, e, d);
    issue(op, arg);
    monitor();
  endtask
  task automatic test_reset();
    cmd.CmdValid = 1'b0; cmd.CmdOp = 2'b11; cmd.CmdArg = '0;
    repeat (2) @(posedge Clk);
    #1;
    total++; if (cmd.CmdReady !== 1'b0) $display("FAIL rst_ready: got %b want 0", cmd.CmdReady); else passed++;
    total++; if ({Busy, Done, CntEn} !== 3'b000) $display("FAIL rst_busy_done_en: got %b want 000", {Busy, Done, CntEn}); else passed++;
    total++; if (CntReset !== 1'b1) $display("FAIL rst_cntreset: got %b want 1", CntReset); else passed++;
    total++; if ({WrapCnt, OvfSeen} !== 9'd0) $display("FAIL rst_wrap_ovf: got %h/%b want 0/0", WrapCnt, OvfSeen); else passed++;
    Reset = 1'b0;
    @(negedge Clk);
    total++; if (cmd.CmdReady !== 1'b1) $display("FAIL rel_ready: got %b want 1", cmd.CmdReady); else passed++;
    total++; if ({CntReset, gray} !== 4'b0000) $display("FAIL rel_cnt: got %b/%b want 0/000", CntReset, gray); else passed++;
    pos = 0; wraps = 0; ovf_m = 0;
  endtask
  task automatic test_step();
    int e, d, bad;
    run_cmd(2'b00, 8'd3, e, d);
    total++; if (m_en !== e) $display("FAIL step3_en: got %0d want %0d", m_en, e); else passed++;
    total++; if (m_done !== d) $display("FAIL step3_done_cycle: got %0d want %0d", m_done, d); else passed++;
    bad = 0;
    for (int k = 0; k < 4; k++) if (gq.size() <= k || gq[k] !== TAB[k]) bad++;
    total++; if (bad !== 0) $display("FAIL step3_gray_seq: got %0d bad cycles want 0", bad); else passed++;
    @(negedge Clk);
    total++; if (gray !== 3'b010) $display("FAIL step3_gray: got %b want 010", gray); else passed++;
    total++; if (WrapCnt !== 8'd0) $display("FAIL step3_wrap: got %0d want 0", WrapCnt); else passed++;
    total++; if (cmd.CmdReady !== 1'b1) $display("FAIL step3_ready: got %b want 1", cmd.CmdReady); else passed++;
  endtask
  task automatic test_step_wrap();
    int e, d;
    run_cmd(2'b01, 8'd0, e, d);
    @(negedge Clk);
    lag_err = 0;
    run_cmd(2'b00, 8'd9, e, d);
    total++; if (m_done !== d) $display("FAIL step9_done_cycle: got %0d want %0d", m_done, d); else passed++;
    @(negedge Clk);
    total++; if (gray !== 3'b001) $display("FAIL step9_gray: got %b want 001", gray); else passed++;
    total++; if (WrapCnt !== 8'd1) $display("FAIL step9_wrap: got %0d want 1", WrapCnt); else passed++;
    total++; if (OvfSeen !== 1'b1) $display("FAIL step9_ovfseen: got %b want 1", OvfSeen); else passed++;
    total++; if (lag_err !== 0) $display("FAIL ovfseen_lag: got %0d lag errors want 0", lag_err); else passed++;
  endtask
  task automatic test_seek();
    int e, d;
    run_cmd(2'b01, 8'd0, e, d);
    @(negedge Clk);
    run_cmd(2'b10, 8'b1111_0101, e, d);
    total++; if (m_en !== 6) $display("FAIL seek101_en: got %0d want 6", m_en); else passed++;
    total++; if (m_done !== 7) $display("FAIL seek101_done_cycle: got %0d want 7", m_done); else passed++;
    @(negedge Clk);
    total++; if (gray !== 3'b101) $display("FAIL seek101_gray: got %b want 101", gray); else passed++;
    run_cmd(2'b10, 8'b0000_0101, e, d);
    total++; if ({m_en, m_done} !== {32'd0, 32'd1}) $display("FAIL seek_same: got en %0d done %0d want en 0 done 1", m_en, m_done); else passed++;
    @(negedge Clk);
    run_cmd(2'b10, 8'd1, e, d);
    total++; if ({m_en, m_done} !== {e, d}) $display("FAIL seek_across_wrap: got en %0d done %0d want en %0d done %0d", m_en, m_done, e, d); else passed++;
    @(negedge Clk);
    total++; if (WrapCnt !== 8'(sat(wraps))) $display("FAIL seek_wrap_cnt: got %0d want %0d", WrapCnt, sat(wraps)); else passed++;
  endtask
  task automatic test_clear();
    int e, d;
    run_cmd(2'b00, 8'd16, e, d);
    @(negedge Clk);
    total++; if (WrapCnt !== 8'(sat(wraps)) || wraps < 2) $display("FAIL clr_pre_wrap: got %0d want %0d", WrapCnt, sat(wraps)); else passed++;
    run_cmd(2'b01, 8'd0, e, d);
    total++; if ({m_rst, m_done, m_en} !== {32'd1, 32'd2, 32'd0}) $display("FAIL clr_timing: got rst %0d done %0d en %0d want 1 2 0", m_rst, m_done, m_en); else passed++;
    @(negedge Clk);
    total++; if ({gray, WrapCnt} !== 11'd0) $display("FAIL clr_result: got %b/%0d want 000/0", gray, WrapCnt); else passed++;
  endtask
  task automatic test_hold_valid();
    int e, d, en_n, done_k, rdy_bad;
    logic [7:0] a2;
    en_n = 0; done_k = 0; rdy_bad = 0;
    model_cmd(2'b00, 8'd5, e, d);
    @(negedge Clk);
    cmd.CmdValid = 1'b1; cmd.CmdOp = 2'b00; cmd.CmdArg = 8'd5;
    @(posedge Clk);
    for (int k = 1; k <= 7; k++) begin
      #1 cmd.CmdArg = 8'($urandom_range(1, 6));
      @(negedge Clk);
      if (k <= 6 && cmd.CmdReady !== 1'b0) rdy_bad++;
      if (k == 7 && cmd.CmdReady !== 1'b1) rdy_bad++;
      if (CntEn) en_n++;
      if (Done) done_k = k;
      @(posedge Clk);
    end
    a2 = cmd.CmdArg;
    #1 cmd.CmdValid = 1'b0;
    total++; if ({en_n, done_k} !== {e, d}) $display("FAIL hold_step5: got en %0d done %0d want %0d %0d", en_n, done_k, e, d); else passed++;
    total++; if (rdy_bad !== 0) $display("FAIL hold_ready: got %0d bad cycles want 0", rdy_bad); else passed++;
    model_cmd(2'b00, a2, e, d);
    monitor();
    total++; if ({m_en, m_done} !== {e, d}) $display("FAIL hold_next_cmd: got en %0d done %0d want %0d %0d", m_en, m_done, e, d); else passed++;
    @(negedge Clk);
    total++; if (gray !== TAB[pos]) $display("FAIL hold_gray: got %b want %b", gray, TAB[pos]); else passed++;
  endtask
  task automatic test_random();
    int e, d, bad;
    logic [1:0] op;
    logic [7:0] arg;
    bad = 0;
    for (int n = 0; n < 30; n++) begin
      op = 2'($urandom);
      arg = op == 2'b00 ? 8'($urandom_range(0, 20)) : 8'($urandom);
      run_cmd(op, arg, e, d);
      if (m_en !== e || m_done !== d) bad++;
      @(negedge Clk);
      if (gray !== TAB[pos] || WrapCnt !== 8'(sat(wraps)) || OvfSeen !== ovf_m || cmd.CmdReady !== 1'b1) bad++;
      total++;
      if (bad !== 0) begin
        $display("FAIL random_cmd%0d op %b arg %0d: en %0d/%0d done %0d/%0d gray %b/%b wrap %0d/%0d ovf %b/%b",
                 n, op, arg, m_en, e, m_done, d, gray, TAB[pos], WrapCnt, sat(wraps), OvfSeen, ovf_m);
        bad = 0;
      end else passed++;
    end
  endtask
  task automatic test_saturate();
    int e, d;
    for (int n = 0; n < 9; n++) begin
      run_cmd(2'b00, 8'd255, e, d);
      @(negedge Clk);
    end
    total++; if (WrapCnt !== 8'(sat(wraps)) || sat(wraps) != 255) $display("FAIL wrap_saturate: got %0d want %0d", WrapCnt, sat(wraps)); else passed++;
    run_cmd(2'b00, 8'd8, e, d);
    @(negedge Clk);
    total++; if (WrapCnt !== 8'd255) $display("FAIL wrap_hold_sat: got %0d want 255", WrapCnt); else passed++;
  endtask
  task automatic test_reset_mid();
    int e, d, bad;
    run_cmd(2'b00, 8'd12, e, d);
    @(negedge Clk);
    issue(2'b00, 8'd200);
    @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    total++; if ({Busy, CntEn, Done, cmd.CmdReady, CntReset} !== 5'b00001) $display("FAIL rmid_async: got %b want 00001", {Busy, CntEn, Done, cmd.CmdReady, CntReset}); else passed++;
    @(posedge Clk);
    #1 Reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      if (Done || CntEn || Busy) bad++;
    end
    total++; if (bad !== 0) $display("FAIL rmid_no_done: got %0d active cycles want 0", bad); else passed++;
    total++; if ({gray, WrapCnt} !== 11'd0) $display("FAIL rmid_cleared: got %b/%0d want 000/0", gray, WrapCnt); else passed++;
    pos = 0; wraps = 0; ovf_m = 0;
    run_cmd(2'b00, 8'd2, e, d);
    total++; if ({m_en, m_done} !== {e, d}) $display("FAIL rmid_recover: got en %0d done %0d want %0d %0d", m_en, m_done, e, d); else passed++;
  endtask
  initial begin
    test_reset();
    test_step();
    test_step_wrap();
    test_seek();
    test_clear();
    test_hold_valid();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gray_step_ctrl.md
# gray_step_ctrl

Command-driven sequencer for the 3-bit Gray-code counter (`En`/`Reset` controlled, `Output`/`Overflow` observed). It accepts STEP, CLEAR and SEEK commands over a valid/ready handshake. For each command it drives the counter's enable and synchronous clear until the command completes, then pulses `Done`. It also keeps a saturating count of full-cycle wraps. It sits between the control logic and the counter instance; the counter is external and connected at the parent level.

## Interface
- `STEP_W`, default 8: width of the STEP count argument.
- `WRAP_W`, default 8: width of the wrap counter.

Ports:
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `CmdValid` input 1: command present.
- `CmdReady` output 1: controller can accept a command.
- `CmdOp` input 2: opcode. 00 = STEP, 01 = CLEAR, 10 = SEEK, 11 = NOP.
- `CmdArg` input `STEP_W`: step count for STEP; `CmdArg[2:0]` is the target Gray code for SEEK.
- `GrayIn` input 3: counter `Output`.
- `OvfIn` input 1: counter `Overflow` (sticky in the counter).
- `CntEn` output 1: drives counter `En`.
- `CntReset` output 1: drives counter `Reset` (synchronous in the counter).
- `Busy` output 1: a command is executing.
- `Done` output 1: one-cycle completion pulse.
- `WrapCnt` output `WRAP_W`: number of 100→000 wraps caused by `CntEn`.
- `OvfSeen` output 1: registered copy of `OvfIn`.

## Operation
- **States:** IDLE, STEP, CLEAR, SEEK, DONE.
- **IDLE**
  - `CmdReady` = 1. A command is accepted at a rising edge with `CmdValid` && `CmdReady`; `CmdOp`/`CmdArg` are captured.
  - STEP with arg 0 → DONE. STEP with arg N > 0 → STEP, with Remain = N.
  - CLEAR → CLEAR.
  - SEEK → SEEK, with Target = `CmdArg[2:0]`.
  - NOP → DONE.
- **STEP**
  - `CntEn` = 1 every cycle.
  - Remain decrements per edge. When Remain == 1 at an edge → DONE.
  - Exactly N enable cycles are issued.
- **CLEAR**
  - `CntReset` = 1 for exactly one cycle, then → DONE.
  - `WrapCnt` clears to 0 on the same edge.
- **SEEK**
  - `CntEn` = (`GrayIn` != Target), combinational. When `GrayIn` == Target → DONE with no further enable.
  - If the target is already current, zero steps are taken. At most 7 enables are issued.
- **DONE**
  - `Done` = 1 for one cycle, then → IDLE.
  - `CmdReady` = 0 in DONE, so there is no back-to-back accept.
- **Busy** = state ∉ {IDLE}.
- **Wrap counting**
  - `WrapCnt` increments at an edge where `CntEn` == 1 and `GrayIn` == 3'b100.
  - Saturates at 2^`WRAP_W` − 1.
  - A CLEAR at the same edge takes priority (result 0).
- **CntReset** = `Reset` | (state == CLEAR). This guarantees the counter clears while global reset is held across an edge.
- **Reset values** (asynchronous): state = IDLE, Remain = 0, Target = 000, `WrapCnt` = 0, `OvfSeen` = 0. `Done`, `CntEn` and `Busy` are 0. `CmdReady` is 0 while `Reset` is high and 1 after release.
- **Reset mid-command:** the command is aborted with no `Done` pulse, and the controller returns to IDLE immediately.

## Timing
- STEP N (N ≥ 1):
  - Accepted at edge 0.
  - `CntEn` is high in cycles 1..N, and `GrayIn` advances at edges 1..N.
  - `Done` is high in cycle N+1.
  - `CmdReady` returns in cycle N+2.
- STEP 0 and NOP: `Done` in cycle 1.
- CLEAR: `CntReset` in cycle 1; the counter reads 000 from edge 1; `Done` in cycle 2.
- SEEK with distance d (0..7, index distance mod 8 along the Gray order): `CntEn` high in cycles 1..d, `Done` in cycle d+1.
- `OvfSeen` lags `OvfIn` by one cycle.
- `CmdOp`/`CmdArg` are sampled only on the accept edge; later changes are ignored.

## Structure
- **Package `gray_ctrl_pkg`:**
  - opcode constants `OP_STEP`, `OP_CLEAR`, `OP_SEEK`, `OP_NOP`;
  - state enum (IDLE, STEP, CLEAR, SEEK, DONE);
  - `GRAY_LAST` = 3'b100;
  - `GRAY_FIRST` = 3'b000.
- **Sub-module `gray_wrap_cnt`:** saturating `WRAP_W` counter with `inc` and `clr` inputs, `clr` having priority.
- The FSM, Remain counter and Target register stay in `gray_step_ctrl`.

## Test plan
The bench instantiates the real Gray counter wired to `CntEn`/`CntReset`.

- Reset, then STEP 3 → `CntEn` high for 3 cycles, `GrayIn` 000→001→011→010, `Done` in cycle 4, `WrapCnt` = 0.
- STEP 9 from 000 → final `GrayIn` = 001, `WrapCnt` = 1, `OvfSeen` = 1 one cycle after the counter's `Overflow` rises.
- SEEK 101 from 000 → 6 enables, `GrayIn` = 101, `Done` in cycle 7. Then SEEK 101 again → 0 enables, `Done` in cycle 1.
- CLEAR after `WrapCnt` = 2 → `CntReset` for one cycle, `GrayIn` = 000, `WrapCnt` = 0, `Done` in cycle 2.
- `CmdValid` held high during a STEP 5 with changing `CmdArg` → no accept until IDLE, next command taken in cycle 7 with the arg present then.
- `Reset` asserted in cycle 2 of STEP 200 → immediate IDLE, `CntEn` = 0, no `Done`, counter reads 000 after the next edge, `WrapCnt` = 0.
